// File: rtl/spi_rx.sv
// SPI slave receiver: oversampled SCK/CS/MOSI, all four CKP/CPH modes, MSB-first words on RX_DATA, response on MISO.
// Optional FRAME_ERR output (partial-word abort pulse) when SPI_FRAME_ERR_EN is defined.
module spi_rx #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CKP,
  input  logic             CPH,
  input  logic             SCK,
  input  logic             CS,
  input  logic             MOSI,
  input  logic [WIDTH-1:0] TX_DATA,
  output logic             MISO,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  output logic             BUSY
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic             FRAME_ERR
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_pipe, cs_pipe, mosi_pipe;
  logic                   sck_s, cs_s, mosi_s, sck_d, cs_d;
  logic                   ckp_q, cph_q;
  logic                   sck_rise, sck_fall, lead, trail, sample, launch;
  logic                   cs_fall, cs_rise, last_bit;
  logic [CW-1:0]          bit_cnt, bit_cnt_nxt;
  logic [WIDTH-2:0]       rx_sr;
  logic [WIDTH-1:0]       rx_word, tx_sr;
  logic                   miso_q;
`ifdef SPI_FRAME_ERR_EN
  logic                   frame_err_q;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sck_pipe  <= '0;
      cs_pipe   <= '1;
      mosi_pipe <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], SCK};
      cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], CS};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], MOSI};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  assign sck_s  = sck_pipe[SYNC_STAGES-1];
  assign cs_s   = cs_pipe[SYNC_STAGES-1];
  assign mosi_s = mosi_pipe[SYNC_STAGES-1];

  always_comb begin
    sck_rise = sck_s & ~sck_d;
    sck_fall = ~sck_s & sck_d;
    lead     = ckp_q ? sck_fall : sck_rise;
    trail    = ckp_q ? sck_rise : sck_fall;
    sample   = cph_q ? trail : lead;
    launch   = cph_q ? lead : trail;
    cs_fall  = cs_d & ~cs_s;
    cs_rise  = ~cs_d & cs_s;
    last_bit = (bit_cnt == CW'(WIDTH - 1));
    rx_word  = {rx_sr, mosi_s};
    bit_cnt_nxt = bit_cnt;
    if (sample) bit_cnt_nxt = last_bit ? '0 : bit_cnt + 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state == ACTIVE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ckp_q    <= 1'b0;
      cph_q    <= 1'b0;
      bit_cnt  <= '0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      miso_q   <= 1'b0;
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      RX_VALID <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
      if (state == IDLE) begin
        ckp_q  <= CKP;
        cph_q  <= CPH;
        miso_q <= 1'b0;
        if (cs_fall) begin
          tx_sr   <= TX_DATA;
          bit_cnt <= '0;
          miso_q  <= CPH ? 1'b0 : TX_DATA[WIDTH-1];
        end
      end else begin
        bit_cnt <= bit_cnt_nxt;
        if (sample) begin
          rx_sr <= rx_word[WIDTH-2:0];
          if (last_bit) begin
            RX_DATA  <= rx_word;
            RX_VALID <= 1'b1;
            tx_sr    <= TX_DATA;
          end
        end
        // A launch with no sample yet in the word only presents the MSB; later launches shift.
        if (launch) begin
          if (bit_cnt != '0) begin
            tx_sr  <= {tx_sr[WIDTH-2:0], 1'b0};
            miso_q <= tx_sr[WIDTH-2];
          end else begin
            miso_q <= tx_sr[WIDTH-1];
          end
        end
        if (cs_rise) begin
          miso_q <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
          frame_err_q <= (bit_cnt_nxt != '0);
`endif
        end
      end
    end
  end

  assign MISO = miso_q;
`ifdef SPI_FRAME_ERR_EN
  assign FRAME_ERR = frame_err_q;
`endif

endmodule
